// File: rtl/ssd_scan_if.sv
// Symbol-bus and display-pin bundle for the 4-digit scan driver.
// master drives symbols and blink controls, slave drives the display pins.
interface ssd_scan_if;
    logic [19:0] code;
    logic [3:0]  blink_mask;
    logic        blink_sync;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    modport master (
        output code, blink_mask, blink_sync,
        input  an, seg, frame_start
    );

    modport slave (
        input  code, blink_mask, blink_sync,
        output an, seg, frame_start
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with frame-locked symbol
// reload, per-digit blinking and anode guard time against ghosting.
module ssd_scan_driver #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLINK_HZ   = 1,
    parameter int GUARD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    ssd_scan_if.slave  bus
);
    localparam int DIGIT_DIV  = CLK_HZ / REFRESH_HZ;
    localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int DW = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [19:0] BLANK4 = {4{5'h13}};

    logic [DW-1:0] div_cnt;
    logic [1:0]    idx;
    logic [19:0]   shadow;
    logic [BW-1:0] blink_cnt;
    logic          phase_off;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          fs_q;

    logic          tick;
    logic          guard;
    logic          blink_wrap;
    logic [4:0]    sym;
    logic [6:0]    glyph;
    logic [3:0]    an_nx;
    logic [6:0]    seg_nx;

    assign tick       = (div_cnt == DW'(DIGIT_DIV - 1));
    assign guard      = (div_cnt < DW'(GUARD_CYC));
    assign blink_wrap = (blink_cnt == BW'(BLINK_HALF - 1));

    assign bus.an          = an_q;
    assign bus.seg         = seg_q;
    assign bus.frame_start = fs_q;

    // Slot timing; symbols are latched only as slot 3 hands over to slot 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            idx     <= 2'd0;
            shadow  <= BLANK4;
            fs_q    <= 1'b0;
        end else begin
            fs_q <= 1'b0;
            if (tick) begin
                div_cnt <= '0;
                idx     <= idx + 2'd1;
                if (idx == 2'd3) begin
                    shadow <= bus.code;
                    fs_q   <= 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Blink phase generator; a sync pulse restarts the ON phase
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            phase_off <= 1'b0;
        end else if (bus.blink_sync) begin
            blink_cnt <= '0;
            phase_off <= 1'b0;
        end else if (blink_wrap) begin
            blink_cnt <= '0;
            phase_off <= ~phase_off;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    // Pick the symbol of the digit currently being scanned
    always_comb begin
        sym = shadow[4:0];
        unique case (idx)
            2'd0: sym = shadow[4:0];
            2'd1: sym = shadow[9:5];
            2'd2: sym = shadow[14:10];
            2'd3: sym = shadow[19:15];
        endcase
    end

    // Symbol to active-low {g,f,e,d,c,b,a}
    always_comb begin
        glyph = 7'h7F;
        case (sym)
            5'h00: glyph = 7'h40;
            5'h01: glyph = 7'h79;
            5'h02: glyph = 7'h24;
            5'h03: glyph = 7'h30;
            5'h04: glyph = 7'h19;
            5'h05: glyph = 7'h12;
            5'h06: glyph = 7'h02;
            5'h07: glyph = 7'h78;
            5'h08: glyph = 7'h00;
            5'h09: glyph = 7'h10;
            5'h0A: glyph = 7'h08;
            5'h0B: glyph = 7'h03;
            5'h0C: glyph = 7'h46;
            5'h0D: glyph = 7'h21;
            5'h0E: glyph = 7'h06;
            5'h0F: glyph = 7'h0E;
            5'h10: glyph = 7'h46;
            5'h11: glyph = 7'h47;
            5'h12: glyph = 7'h3F;
            5'h14: glyph = 7'h0C;
            5'h15: glyph = 7'h2B;
            5'h16: glyph = 7'h23;
            5'h17: glyph = 7'h2F;
            5'h18: glyph = 7'h41;
            default: glyph = 7'h7F;
        endcase
    end

    // Next pin values: dark during the guard window, blanked in blink OFF
    always_comb begin
        an_nx  = 4'hF;
        seg_nx = 7'h7F;
        if (!guard) begin
            an_nx = ~(4'b0001 << idx);
            if (!(bus.blink_mask[idx] && phase_off)) begin
                seg_nx = glyph;
            end
        end
    end

    // Registered pins so the display never sees combinational glitches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 4'hF;
            seg_q <= 7'h7F;
        end else begin
            an_q  <= an_nx;
            seg_q <= seg_nx;
        end
    end
endmodule

// File: tb/tb_ssd_scan_driver.sv
// Self-checking bench for ssd_scan_driver: directed scenarios plus
// randomized symbols/mask/sync against a time-based reference model.
module tb_ssd_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    ssd_scan_if bus ();

    ssd_scan_driver #(
        .CLK_HZ    (1000),
        .REFRESH_HZ(100),
        .BLINK_HZ  (1),
        .GUARD_CYC (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int k = 0;
    int last_sync = 0;
    logic [19:0] cur_code;
    logic [3:0]  cur_mask;
    logic        cur_sync;
    logic [19:0] sh;
    logic [6:0]  dec [32];

    task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic apply();
        bus.code       = cur_code;
        bus.blink_mask = cur_mask;
        bus.blink_sync = cur_sync;
    endtask

    // One clock: compare all pins with the model, then advance the model
    task automatic step();
        int n, dv, id;
        logic [3:0] ea;
        logic [6:0] es;
        logic [4:0] s;
        bit off;
        @(posedge clk);
        #1;
        k++;
        n  = k - 1;
        dv = n % 10;
        id = (n / 10) % 4;
        ea = 4'hF;
        es = 7'h7F;
        if (dv >= 2) begin
            ea  = 4'hF & ~(4'd1 << id);
            s   = sh[5*id +: 5];
            off = (((n - last_sync) / 500) % 2) == 1;
            es  = (cur_mask[id] && off) ? 7'h7F : dec[s];
        end
        chk("an", bus.an, ea);
        chk("seg", bus.seg, es);
        chk("frame_start", bus.frame_start, (k % 40 == 0) ? 7'd1 : 7'd0);
        if (k % 40 == 0) sh = cur_code;
        if (cur_sync) last_sync = k;
        cur_sync = 1'b0;
        apply();
    endtask

    task automatic run_to(int t);
        while (k < t) step();
    endtask

    task automatic model_reset();
        k = 0;
        last_sync = 0;
        sh = {4{5'h13}};
    endtask

    initial begin
        dec = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                7'h46, 7'h47, 7'h3F, 7'h7F, 7'h0C, 7'h2B, 7'h23, 7'h2F,
                7'h41, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        cur_code = 20'h844AD;
        cur_mask = 4'h0;
        cur_sync = 1'b0;
        apply();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", bus.an, 4'hF);
        chk("rst_seg", bus.seg, 7'h7F);
        chk("rst_fs", bus.frame_start, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        run_to(33);
        chk("blank_an3", bus.an, 4'h7);
        chk("blank_seg3", bus.seg, 7'h7F);
        run_to(40);
        chk("wrap_fs", bus.frame_start, 1'b1);
        run_to(41);
        chk("guard_an", bus.an, 4'hF);
        chk("guard_seg", bus.seg, 7'h7F);
        run_to(43);
        chk("d0_an", bus.an, 4'hE);
        chk("d0_seg", bus.seg, 7'h21);
        run_to(53);
        chk("d1_an", bus.an, 4'hD);
        chk("d1_seg", bus.seg, 7'h12);
        run_to(55);
        cur_code = 20'h00000;
        apply();
        run_to(63);
        chk("tear_d2", bus.seg, 7'h47);
        run_to(73);
        chk("tear_d3_an", bus.an, 4'h7);
        chk("tear_d3", bus.seg, 7'h46);
        run_to(83);
        chk("new_d0", bus.seg, 7'h40);

        cur_mask = 4'b1000;
        apply();
        run_to(433);
        chk("blink_on", bus.seg, 7'h40);
        run_to(553);
        chk("blink_off", bus.seg, 7'h7F);
        run_to(563);
        chk("blink_d0", bus.seg, 7'h40);
        run_to(750);
        cur_sync = 1'b1;
        apply();
        run_to(753);
        chk("sync_on", bus.seg, 7'h40);
        run_to(1233);
        chk("sync_hold", bus.seg, 7'h40);
        run_to(1273);
        chk("sync_off", bus.seg, 7'h7F);

        run_to(1275);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_an", bus.an, 4'hF);
        chk("arst_seg", bus.seg, 7'h7F);
        chk("arst_fs", bus.frame_start, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cur_mask = 4'h0;
        apply();
        run_to(39);
        chk("arst_fs39", bus.frame_start, 1'b0);
        run_to(40);
        chk("arst_fs40", bus.frame_start, 1'b1);

        for (int c = 0; c < 32; c++) begin
            cur_code = {15'h2108, 5'(c)};
            apply();
            run_to(k + 40);
        end

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(29) == 0) cur_code = 20'($urandom);
            if ($urandom_range(199) == 0) cur_mask = 4'($urandom);
            if ($urandom_range(399) == 0) cur_sync = 1'b1;
            apply();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
